// File: rtl/up_counter.sv
// rtl/up_counter.sv - start/run/done up counter with preload, doubling and saturate-or-wrap overflow
// Count updates (load > double > increment) are independent of the run FSM, which only gates increments.
module up_counter #(
  parameter int WIDTH = 8,
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gload,
  input  logic             multiply_by_2,
  input  logic [WIDTH-1:0] preload_count,
  input  logic [WIDTH-1:0] terminal_count,
  output logic [WIDTH-1:0] count_out,
  output logic             full,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             at_term;
  logic             at_max;
  logic             count_override;

  always_comb begin
    at_term        = (count_q == term_q);
    at_max         = (count_q == ALL_ONES);
    count_override = gload | multiply_by_2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      term_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;

    if (gload) begin
      count_d = preload_count;
    end else if (multiply_by_2) begin
      // Saturating mode clamps instead of dropping a set MSB.
      if ((WRAP == 0) && count_q[WIDTH-1]) begin
        count_d = ALL_ONES;
      end else begin
        count_d = count_q << 1;
      end
    end else if ((state_q == S_RUN) && !at_term) begin
      if (at_max) begin
        count_d = (WRAP != 0) ? '0 : ALL_ONES;
      end else begin
        count_d = count_q + ONE;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          term_d  = terminal_count;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A stuck-at-max saturating count can never reach a higher terminal, so it ends the run.
        if (!count_override && (at_term || ((WRAP == 0) && at_max))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    count_out = count_q;
    full      = at_max;
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_up_counter.sv
// tb/tb_up_counter.sv - saturating and wrapping counters driven in lockstep against an arithmetic reference
module tb_up_counter;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       gload = 1'b0;
  logic       multiply_by_2 = 1'b0;
  logic [7:0] preload_count = 8'd0;
  logic [7:0] terminal_count = 8'd0;

  logic [7:0] count_sat, count_wrp;
  logic       full_sat, full_wrp;
  logic       busy_sat, busy_wrp;
  logic       done_sat, done_wrp;

  int vectors = 0;
  int miscompares = 0;

  int m_cnt[2];
  int m_ph[2];
  int m_trm[2];
  int done_pulses[2];
  int busy_cycles[2];

  always #5 clk = ~clk;

  up_counter #(.WIDTH(8), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .start(start), .gload(gload), .multiply_by_2(multiply_by_2),
    .preload_count(preload_count), .terminal_count(terminal_count),
    .count_out(count_sat), .full(full_sat), .busy(busy_sat), .done(done_sat)
  );

  up_counter #(.WIDTH(8), .WRAP(1)) u_wrp (
    .clk(clk), .rst(rst), .start(start), .gload(gload), .multiply_by_2(multiply_by_2),
    .preload_count(preload_count), .terminal_count(terminal_count),
    .count_out(count_wrp), .full(full_wrp), .busy(busy_wrp), .done(done_wrp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input int k, input bit r, input bit s, input bit g, input bit m,
                       input int pre, input int tc);
    int cnt;
    int nph;
    cnt = m_cnt[k];
    if (r) begin
      m_cnt[k] = 0;
      m_ph[k]  = PH_IDLE;
      m_trm[k] = 0;
    end else begin
      nph = m_ph[k];
      if (g) m_cnt[k] = pre;
      else if (m) m_cnt[k] = (cnt * 2 > 255) ? ((k == 1) ? (cnt * 2) % 256 : 255) : cnt * 2;
      else if (m_ph[k] == PH_RUN && cnt != m_trm[k]) m_cnt[k] = (k == 1) ? (cnt + 1) % 256 : ((cnt + 1 > 255) ? 255 : cnt + 1);
      if (m_ph[k] == PH_IDLE) begin
        if (s) begin
          m_trm[k] = tc;
          nph = PH_RUN;
        end
      end else if (m_ph[k] == PH_RUN) begin
        if (!g && !m && (cnt == m_trm[k] || (k == 0 && cnt == 255))) nph = PH_DONE;
      end else begin
        nph = PH_IDLE;
      end
      m_ph[k] = nph;
    end
  endtask

  task automatic check_all();
    check("sat.count", count_sat, m_cnt[0]);
    check("sat.busy", busy_sat, m_ph[0] == PH_RUN);
    check("sat.done", done_sat, m_ph[0] == PH_DONE);
    check("sat.full", full_sat, m_cnt[0] == 255);
    check("wrp.count", count_wrp, m_cnt[1]);
    check("wrp.busy", busy_wrp, m_ph[1] == PH_RUN);
    check("wrp.done", done_wrp, m_ph[1] == PH_DONE);
    check("wrp.full", full_wrp, m_cnt[1] == 255);
  endtask

  task automatic step(input bit r, input bit s, input bit g, input bit m, input int pre, input int tc);
    rst = r;
    start = s;
    gload = g;
    multiply_by_2 = m;
    preload_count = pre[7:0];
    terminal_count = tc[7:0];
    for (int k = 0; k < 2; k++) model(k, r, s, g, m, pre, tc);
    @(posedge clk);
    #1;
    check_all();
    if (done_sat) done_pulses[0]++;
    if (done_wrp) done_pulses[1]++;
    if (busy_sat) busy_cycles[0]++;
    if (busy_wrp) busy_cycles[1]++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 8'h55, 8'h33);
    check("reset.count", count_sat, 8'h00);
    check("reset.flags", {full_sat, busy_sat, done_sat}, 3'b000);

    // Basic run to 5 from 0
    done_pulses = '{0, 0};
    busy_cycles = '{0, 0};
    step(0, 1, 0, 0, 0, 5);
    idle(9);
    check("run5.count", count_sat, 8'h05);
    check("run5.busy_cycles", busy_cycles[0], 6);
    check("run5.done_pulses", done_pulses[0], 1);

    // gload beats multiply_by_2, then doubling alone
    step(0, 0, 1, 1, 8'h0A, 0);
    check("gload_wins", count_sat, 8'h0A);
    step(0, 0, 0, 1, 0, 0);
    check("double", count_wrp, 8'h14);

    // Doubling with MSB set; saturating run ends at all-ones
    step(0, 0, 1, 0, 8'hC0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("double_sat", {full_sat, count_sat}, {1'b1, 8'hFF});
    check("double_wrp", count_wrp, 8'h80);
    done_pulses = '{0, 0};
    step(0, 1, 0, 0, 0, 8'h10);
    idle(160);
    check("sat_end.count", count_sat, 8'hFF);
    check("sat_end.done_pulses", done_pulses[0], 1);
    check("wrp_end.count", count_wrp, 8'h10);

    // Wrap through zero to terminal 1
    step(0, 0, 1, 0, 8'hFE, 0);
    done_pulses = '{0, 0};
    step(0, 1, 0, 0, 0, 8'h01);
    step(0, 0, 0, 0, 0, 0);
    check("wrap.ff", count_wrp, 8'hFF);
    step(0, 0, 0, 0, 0, 0);
    check("wrap.00", count_wrp, 8'h00);
    idle(5);
    check("wrap.end", count_wrp, 8'h01);
    check("wrap.done_pulses", done_pulses[1], 1);

    // Reset mid-run at count 3
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 10);
    idle(3);
    check("midrun.at3", count_sat, 8'h03);
    done_pulses = '{0, 0};
    step(1, 1, 0, 0, 0, 10);
    check("midrun.reset", {count_sat, busy_sat, done_sat}, {8'h00, 1'b0, 1'b0});
    idle(6);
    check("midrun.no_done", done_pulses[0], 0);

    // Restart during run is ignored
    step(0, 1, 0, 0, 0, 6);
    idle(2);
    step(0, 1, 0, 0, 0, 2);
    idle(8);
    check("restart_ignored", count_sat, 8'h06);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit r, s, g, m;
      int pre, tc;
      r = ($urandom_range(0, 31) == 0);
      s = ($urandom_range(0, 3) == 0);
      g = ($urandom_range(0, 7) == 0);
      m = ($urandom_range(0, 7) == 0);
      pre = $urandom_range(0, 255);
      tc = ($urandom_range(0, 1) == 0) ? (m_cnt[0] + $urandom_range(0, 12)) % 256 : $urandom_range(0, 255);
      step(r, s, g, m, pre, tc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/up_counter.md
UP_COUNTER -- requirements
Module: up_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning counter and data-port width in bits.
REQ-002 SHALL provide parameter WRAP, default 0, meaning overflow policy: 0 = saturate at all-ones, 1 = wrap modulo 2^WIDTH.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  request to begin a count run toward terminal_count.
REQ-006 SHALL provide port gload  input  1  load count_out from preload_count.
REQ-007 SHALL provide port multiply_by_2  input  1  left-shift count_out by one.
REQ-008 SHALL provide port preload_count  input  WIDTH  load value.
REQ-009 SHALL provide port terminal_count  input  WIDTH  run end value, sampled on accepted start.
REQ-010 SHALL provide port count_out  output  WIDTH  current count, registered.
REQ-011 SHALL provide port full  output  1  high while count_out equals all-ones, combinational from count_out.
REQ-012 SHALL provide port busy  output  1  high while FSM is in RUN.
REQ-013 SHALL provide port done  output  1  one-cycle pulse while FSM is in DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1, capture terminal_count into internal term_reg and enter RUN next cycle.
REQ-016 SHALL ignore start while in RUN or DONE.
REQ-017 SHALL transition from DONE to IDLE unconditionally after one cycle.
REQ-018 SHALL apply count-update priority in every state: gload > multiply_by_2 > increment; increment occurs only in RUN.
REQ-019 SHALL, on gload=1, set count_out to preload_count next cycle.
REQ-020 SHALL, on multiply_by_2=1 without gload, set count_out to count_out<<1 with LSB 0; if WRAP=0 and count_out MSB=1, set count_out to all-ones instead.
REQ-021 SHALL, in RUN without gload or multiply_by_2, and with count_out != term_reg, increment count_out by 1.
REQ-022 SHALL, on increment at all-ones, hold all-ones if WRAP=0, or wrap to 0 if WRAP=1.
REQ-023 SHALL, in RUN with count_out == term_reg and neither gload nor multiply_by_2 asserted, hold count_out and enter DONE next cycle.
REQ-024 SHALL, in RUN with WRAP=0 and count_out all-ones and term_reg != all-ones, enter DONE next cycle (saturation terminates run).
REQ-025 SHALL treat IDLE start with simultaneous gload as both: load preload_count and enter RUN in the same cycle.
REQ-026 SHALL, when start is accepted with count_out already equal to terminal_count, enter RUN then DONE one cycle later with no increment.
REQ-027 SHALL evaluate the term_reg match on the registered count_out, so done asserts one cycle after count_out first equals term_reg.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set state IDLE, count_out 0, term_reg 0; therefore busy=0, done=0, full=0.
REQ-029 SHALL give rst priority over start, gload and multiply_by_2, including mid-RUN and in DONE.

Verification
REQ-030 SHALL cover: rst, then start with terminal_count=5, count_out=0 -> count_out 1..5 over 5 cycles, busy high 6 cycles, done pulses once, count_out holds 5.
REQ-031 SHALL cover: gload with preload_count=8'h0A and multiply_by_2 in the same cycle -> count_out=8'h0A (gload wins); next cycle multiply_by_2 alone -> 8'h14.
REQ-032 SHALL cover, with WRAP=0: count_out=8'hC0, multiply_by_2 -> 8'hFF, full=1; RUN with terminal_count=8'h10 ending at 8'hFF -> done pulses, count_out stays 8'hFF.
REQ-033 SHALL cover, with WRAP=1: count_out=8'hFE, start with terminal_count=8'h01 -> count_out FF, 00, 01, then done pulse.
REQ-034 SHALL cover: rst asserted mid-RUN at count_out=3 -> next cycle count_out=0, busy=0, done=0, no done pulse follows.
REQ-035 SHALL cover: start reasserted during RUN with new terminal_count=2 -> ignored, run ends at originally captured term_reg.
